// File: rtl/sprite_line_renderer_if.sv
// Memory-side bus of the sprite line renderer: sprite attribute RAM,
// VRAM fetch handshake and the line buffer render port.
interface sprite_line_renderer_if;
    logic [5:0]  spr_sel;
    logic [8:0]  spr_x;
    logic [7:0]  spr_y;
    logic [8:0]  spr_tile;
    logic [1:0]  spr_pal;
    logic        spr_hflip;
    logic        spr_vflip;
    logic        spr_prio;
    logic        spr_enable;
    logic        spr_h16;

    logic        vram_req;
    logic [12:0] vram_addr;
    logic        vram_ack;
    logic [15:0] vram_rddata;

    logic [8:0]  lb_idx;
    logic [7:0]  lb_wrdata;
    logic        lb_wren;
    logic [7:0]  lb_rddata;

    modport master (
        output spr_sel,
        input  spr_x, spr_y, spr_tile, spr_pal,
        input  spr_hflip, spr_vflip, spr_prio, spr_enable, spr_h16,
        output vram_req, vram_addr,
        input  vram_ack, vram_rddata,
        output lb_idx, lb_wrdata, lb_wren,
        input  lb_rddata
    );

    modport slave (
        input  spr_sel,
        output spr_x, spr_y, spr_tile, spr_pal,
        output spr_hflip, spr_vflip, spr_prio, spr_enable, spr_h16,
        input  vram_req, vram_addr,
        output vram_ack, vram_rddata,
        input  lb_idx, lb_wrdata, lb_wren,
        output lb_rddata
    );
endinterface

// File: rtl/sprite_line_renderer.sv
// Scans the sprite table for one scanline, fetches one 4bpp pattern row per
// hit sprite and read-modify-writes its pixels into the back line buffer.
module sprite_line_renderer #(
    parameter int NUM_SPRITES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    line,
    output logic                          busy,
    output logic                          done,
    sprite_line_renderer_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTR,
        S_EVAL,
        S_FETCH0,
        S_FETCH1,
        S_PIX_RD,
        S_PIX_WR,
        S_DONE
    } state_t;

    state_t      state_reg;
    logic [7:0]  line_reg;
    logic [5:0]  idx_reg;
    logic [2:0]  pix_reg;
    logic [8:0]  x_reg;
    logic [1:0]  pal_reg;
    logic        hflip_reg;
    logic        prio_reg;
    logic [15:0] word0_reg;
    logic [15:0] word1_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        vram_req_reg;
    logic [12:0] vram_addr_reg;
    logic [8:0]  lb_idx_reg;

    // Sprite evaluation against the target line (valid in EVAL)
    logic [7:0]  dy;
    logic        hit;
    logic [3:0]  row_sel;
    logic [12:0] fetch_base;
    logic        last_sprite;

    always_comb begin
        dy         = line_reg - bus.spr_y;
        hit        = bus.spr_enable && (dy < (bus.spr_h16 ? 8'd16 : 8'd8));
        row_sel    = bus.spr_vflip ? ((bus.spr_h16 ? 4'd15 : 4'd7) - dy[3:0]) : dy[3:0];
        if (!bus.spr_h16) begin
            row_sel[3] = 1'b0;
        end
        fetch_base = ((13'(bus.spr_tile) + 13'(row_sel[3])) << 4)
                   | {9'd0, row_sel[2:0], 1'b0};
        last_sprite = (idx_reg == 6'(NUM_SPRITES - 1));
    end

    // Pattern row split into its eight 4-bit pixels, pixel 0 in the top nibble
    logic [31:0] pattern_row;
    logic [3:0]  pattern_nib [8];
    assign pattern_row = {word0_reg, word1_reg};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            assign pattern_nib[gi] = pattern_row[31 - 4*gi -: 4];
        end
    endgenerate

    logic [2:0] pat_sel;
    logic [3:0] colour;
    logic       wr_ok;

    always_comb begin
        pat_sel = hflip_reg ? (3'd7 - pix_reg) : pix_reg;
        colour  = pattern_nib[pat_sel];
        wr_ok   = (state_reg == S_PIX_WR) && (colour != 4'd0) && !bus.lb_rddata[6]
                && (prio_reg || !bus.lb_rddata[7]);
    end

    // The write decision needs the line buffer byte read back in this very
    // cycle, so the write strobe and data are decoded rather than registered.
    assign bus.lb_wren   = wr_ok;
    assign bus.lb_wrdata = wr_ok ? {bus.lb_rddata[7], 1'b1, pal_reg, colour} : 8'd0;

    logic unused_lb_bits;
    assign unused_lb_bits = ^bus.lb_rddata[5:0];

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign bus.spr_sel   = idx_reg;
    assign bus.vram_req  = vram_req_reg;
    assign bus.vram_addr = vram_addr_reg;
    assign bus.lb_idx    = lb_idx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            line_reg      <= 8'd0;
            idx_reg       <= 6'd0;
            pix_reg       <= 3'd0;
            x_reg         <= 9'd0;
            pal_reg       <= 2'd0;
            hflip_reg     <= 1'b0;
            prio_reg      <= 1'b0;
            word0_reg     <= 16'd0;
            word1_reg     <= 16'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            vram_req_reg  <= 1'b0;
            vram_addr_reg <= 13'd0;
            lb_idx_reg    <= 9'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        line_reg  <= line;
                        idx_reg   <= 6'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_ATTR;
                    end
                end
                S_ATTR: begin
                    state_reg <= S_EVAL;
                end
                S_EVAL: begin
                    if (hit) begin
                        x_reg         <= bus.spr_x;
                        pal_reg       <= bus.spr_pal;
                        hflip_reg     <= bus.spr_hflip;
                        prio_reg      <= bus.spr_prio;
                        vram_req_reg  <= 1'b1;
                        vram_addr_reg <= fetch_base;
                        state_reg     <= S_FETCH0;
                    end else if (last_sprite) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 6'd1;
                        state_reg <= S_ATTR;
                    end
                end
                S_FETCH0: begin
                    if (bus.vram_ack) begin
                        word0_reg     <= bus.vram_rddata;
                        vram_addr_reg <= vram_addr_reg | 13'd1;
                        state_reg     <= S_FETCH1;
                    end
                end
                S_FETCH1: begin
                    if (bus.vram_ack) begin
                        word1_reg    <= bus.vram_rddata;
                        vram_req_reg <= 1'b0;
                        pix_reg      <= 3'd0;
                        lb_idx_reg   <= x_reg;
                        state_reg    <= S_PIX_RD;
                    end
                end
                S_PIX_RD: begin
                    state_reg <= S_PIX_WR;
                end
                S_PIX_WR: begin
                    if (pix_reg == 3'd7) begin
                        if (last_sprite) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            idx_reg   <= idx_reg + 6'd1;
                            state_reg <= S_ATTR;
                        end
                    end else begin
                        // 9-bit sum wraps past the right edge back to pixel 0
                        pix_reg    <= pix_reg + 3'd1;
                        lb_idx_reg <= x_reg + {6'd0, pix_reg} + 9'd1;
                        state_reg  <= S_PIX_RD;
                    end
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Renders the sprite layer for one scanline into the back half of the double-buffered line buffer. The block scans the sprite attribute table and tests each sprite against the target line. For every hit it fetches one 8-pixel 4bpp pattern row from VRAM, then read-modify-writes the pixels into the line buffer's render port. It sits between the sprite attribute RAM / VRAM arbiter and the line buffer, and runs after the tile renderer within the same line period.

## Interface
- NUM_SPRITES, 64: sprites scanned per line, indices 0..NUM_SPRITES-1 (max 64).
- clk  in  1  video clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: render line `line`
- line  in  8  target line number, sampled when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the scan completes
- spr_sel  out  6  attribute RAM index; attributes valid one cycle later
- spr_x  in  9; spr_y  in  8; spr_tile  in  9; spr_pal  in  2
- spr_hflip, spr_vflip, spr_prio, spr_enable, spr_h16  in  1 each
- vram_req  out  1; vram_addr  out  13 (16-bit word address); vram_ack  in  1; vram_rddata  in  16
- lb_idx  out  9; lb_wrdata  out  8; lb_wren  out  1; lb_rddata  in  8 (1-cycle read latency)

## Operation
- Line-buffer byte format: bit7 = tile priority (set by the tile renderer); bit6 = sprite already drawn; bits5:0 = {palette, colour}.
- States and transitions:
  - IDLE: start=1 latches line, sets sprite idx=0, goes to ATTR. start is ignored in every other state.
  - ATTR: drive spr_sel=idx, go to EVAL.
  - EVAL: latch attributes and compute dy = (line − spr_y) mod 256.
    - Hit = spr_enable && dy < (spr_h16 ? 16 : 8).
    - On a hit, go to FETCH0.
    - Otherwise go to ATTR with idx+1, or to DONE if idx = NUM_SPRITES−1.
  - FETCH0 / FETCH1: vram_req=1 with vram_addr = ((tile + r[3]) << 4) | (r[2:0] << 1) | w, where w=0/1 and all arithmetic is 13-bit.
    - r = dy[3:0]. With vflip, r = (h16 ? 15 : 7) − dy[3:0]. For 8-high sprites, r[3]=0.
    - Latch vram_rddata in the cycle vram_ack=1, then advance: FETCH0 → FETCH1, FETCH1 → PIX_RD with i=0.
  - PIX_RD: lb_idx = (spr_x + i) mod 512, lb_wren=0, go to PIX_WR.
  - PIX_WR: same lb_idx. Write if colour≠0 && !lb_rddata[6] && (spr_prio || !lb_rddata[7]).
    - Written byte: lb_wrdata = {lb_rddata[7], 1, spr_pal, colour}.
    - Then i+1 and back to PIX_RD. After i=7, go to ATTR with idx+1, or to DONE if this was the last sprite.
  - DONE: done=1 for one cycle, go to IDLE.
- Pixel colours: row = {word0, word1}. Pattern pixel p has colour row[31−4p −: 4]. Output pixel i uses p = hflip ? 7−i : i.
- Lower sprite index wins; bit6 blocks later sprites. There is no clipping: idx wraps mod 512.

## Timing
- Reset values: busy=0, done=0, spr_sel=0, vram_req=0, vram_addr=0, lb_idx=0, lb_wren=0, lb_wrdata=0; state IDLE.
- Start sampled in cycle T: first ATTR is in T+1.
- Per non-hit sprite: 2 cycles.
- Per hit sprite: 2 + fetch cycles + 16 cycles.
- Fetch: at least 1 cycle per word. vram_addr is held stable while vram_req=1 and no ack. An ack in the same cycle as req is legal.
- With no hits and NUM_SPRITES=64, done is high in cycle T+129 and busy is high from T+1 to T+129.
- lb_wren is only ever high in PIX_WR, never in consecutive cycles.
- Reset mid-operation: next cycle IDLE with all outputs at reset values. vram_req drops without an ack and no done is produced.

## Test plan
- All sprites disabled, start at T → done only at T+129; lb_wren and vram_req never high.
- Sprite 0: x=100, y=10, tile=5, pal=2, line=12, zero-wait ack, words 0x1230 / 0x4567, lb_rddata=0x00:
  - vram_addr 84 then 85.
  - Writes idx 100,101,102 = 0x61,0x62,0x63; idx 103 skipped; idx 104..107 = 0x64..0x67.
- Same sprite with h16=1, vflip=1, hflip=1, line=13:
  - vram_addr 104 then 105.
  - idx 100 gets colour 7 (0x67), idx 107 gets colour 1 (0x61).
- Priority cases:
  - lb_rddata=0x80, prio=0 → no writes.
  - prio=1 → writes 0xE1-style bytes {1,1,pal,c}.
  - lb_rddata=0x40 → no writes.
- x=508 hit: writes at idx 508..511 then 0..3, in order.
- Reset asserted during FETCH0 with ack withheld → vram_req=0 and busy=0 next cycle, no done; a fresh start renders correctly.
